csr_unit: RTL and testbench

- Parametrised successor to the first-generation machine-mode CSR execute unit, with one-cycle writeback into the backend execute stage.
- Implements CSRRW/CSRRS/CSRRC with correct per-field write masks.
- Adds mscratch, mcycle/minstret counters with read-only user shadows, and live interrupt-pending inputs.
- Adds hardware trap-entry and MRET sequencing, plus illegal-access detection.

---
 rtl/csr_unit.sv | 164 ++++++++++++++++
 tb/tb_csr_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR execute unit: CSRRW/CSRRS/CSRRC with per-field masks, counters,
// trap entry and MRET sequencing, with a registered one-cycle writeback.
module csr_unit #(
  parameter int unsigned     XLEN   = 64,
  parameter int unsigned     RB     = 2,
  parameter logic [XLEN-1:0] HARTID = '0,
  parameter bit              CNT_EN = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                csr_exeparam_valid,
  input  logic [XLEN+RB+20:0] csr_exeparam,
  input  logic                flush,
  input  logic                trap_valid,
  input  logic [XLEN-1:0]     trap_cause,
  input  logic [XLEN-1:0]     trap_epc,
  input  logic [XLEN-1:0]     trap_tval,
  input  logic                mret_valid,
  input  logic [1:0]          retire_cnt,
  input  logic                irq_msip,
  input  logic                irq_mtip,
  input  logic                irq_meip,
  output logic                csr_writeback_valid,
  output logic [XLEN-1:0]     csr_res_qout,
  output logic [RB+4:0]       csr_rd0_qout,
  output logic                csr_illegal,
  output logic [XLEN-1:0]     mtvec_qout,
  output logic [XLEN-1:0]     mepc_qout,
  output logic                mstatus_mie,
  output logic [XLEN-1:0]     mip_mie_qout
);

  localparam logic [XLEN-1:0] MstatusMask = XLEN'(64'h88);
  localparam logic [XLEN-1:0] MppBits     = XLEN'(64'h1800);
  localparam logic [XLEN-1:0] MieMask     = XLEN'(64'h888);
  localparam logic [XLEN-1:0] LowTwoMask  = ~XLEN'(64'h3);
  localparam logic [XLEN-1:0] MisaVal     = {2'b10, 36'b0, 26'h100};

  logic [11:0]     addr;
  logic [XLEN-1:0] op;
  logic [RB+4:0]   rd0;
  logic            rs1_zero, is_rc, is_rs, is_rw;

  assign {is_rw, is_rs, is_rc, rs1_zero, rd0, op, addr} = csr_exeparam;

  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q, res_q;
  logic [RB+4:0]   rd0_q;
  logic            wb_valid_q, illegal_q;

  logic [XLEN-1:0] mip_val, rdata, wdata;
  logic            known, read_only, wr_intent, illegal, op_act, op_take, do_wr;

  always_comb begin
    mip_val     = '0;
    mip_val[3]  = irq_msip;
    mip_val[7]  = irq_mtip;
    mip_val[11] = irq_meip;
  end

  // Read view of every implemented CSR; this is also the "old" value for set/clear.
  always_comb begin
    rdata     = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (addr)
      12'hF11, 12'hF12, 12'hF13: read_only = 1'b1;
      12'hF14: begin
        read_only = 1'b1;
        rdata     = HARTID;
      end
      12'h301: rdata = MisaVal;
      12'h300: rdata = mstatus_q | MppBits;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_val;
      12'hB00: rdata = mcycle_q;
      12'hB02: rdata = minstret_q;
      12'hC00: begin
        read_only = 1'b1;
        rdata     = mcycle_q;
      end
      12'hC02: begin
        read_only = 1'b1;
        rdata     = minstret_q;
      end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    wr_intent = is_rw | (~rs1_zero & (is_rs | is_rc));
    illegal   = !$onehot({is_rw, is_rs, is_rc}) | ~known | (read_only & wr_intent);
    // Trap and MRET pre-empt any CSR op in the same cycle.
    op_act    = csr_exeparam_valid & ~trap_valid & ~mret_valid;
    op_take   = op_act & ~flush & ~illegal;
    do_wr     = op_take & wr_intent;
    wdata     = is_rw ? op : (is_rs ? (rdata | op) : (rdata & ~op));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      res_q      <= '0;
      rd0_q      <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      wb_valid_q <= op_take;
      illegal_q  <= op_act & ~flush & illegal;
      res_q      <= (op_take & ~(is_rw & (rd0 == '0))) ? rdata : '0;
      rd0_q      <= op_take ? rd0 : '0;
      mcycle_q   <= CNT_EN ? mcycle_q + XLEN'(1) : mcycle_q;
      minstret_q <= CNT_EN ? minstret_q + XLEN'(retire_cnt) : minstret_q;
      // A CSR write to a counter overrides that cycle's increment.
      if (do_wr) begin
        case (addr)
          12'h300: mstatus_q  <= wdata & MstatusMask;
          12'h304: mie_q      <= wdata & MieMask;
          12'h305: mtvec_q    <= wdata & LowTwoMask;
          12'h340: mscratch_q <= wdata;
          12'h341: mepc_q     <= wdata & LowTwoMask;
          12'h342: mcause_q   <= wdata;
          12'h343: mtval_q    <= wdata;
          12'hB00: mcycle_q   <= wdata;
          12'hB02: minstret_q <= wdata;
          default: ;
        endcase
      end
      if (trap_valid) begin
        mepc_q       <= trap_epc & LowTwoMask;
        mcause_q     <= trap_cause;
        mtval_q      <= trap_tval;
        mstatus_q[7] <= mstatus_q[3];
        mstatus_q[3] <= 1'b0;
      end else if (mret_valid) begin
        mstatus_q[3] <= mstatus_q[7];
        mstatus_q[7] <= 1'b1;
      end
    end
  end

  assign csr_writeback_valid = wb_valid_q;
  assign csr_illegal         = illegal_q;
  assign csr_res_qout        = res_q;
  assign csr_rd0_qout        = rd0_q;
  assign mtvec_qout          = mtvec_q;
  assign mepc_qout           = mepc_q;
  assign mstatus_mie         = mstatus_q[3];
  assign mip_mie_qout        = mip_val & mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: a behavioural CSR model checked every cycle, plus
// hand-computed literal expectations along the directed sequence.
module tb_csr_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned RB   = 2;
  localparam int unsigned TW   = 5 + RB;
  localparam logic [63:0] HART = 64'h7;
  localparam logic [2:0]  RW   = 3'b100;
  localparam logic [2:0]  RS   = 3'b010;
  localparam logic [2:0]  RC   = 3'b001;

  logic              CLK = 1'b0;
  logic              RST;
  logic              csr_exeparam_valid;
  logic [XLEN+RB+20:0] csr_exeparam;
  logic              flush, trap_valid, mret_valid;
  logic [63:0]       trap_cause, trap_epc, trap_tval;
  logic [1:0]        retire_cnt;
  logic              irq_msip, irq_mtip, irq_meip;
  logic              csr_writeback_valid, csr_illegal, mstatus_mie;
  logic [63:0]       csr_res_qout, mtvec_qout, mepc_qout, mip_mie_qout;
  logic [TW-1:0]     csr_rd0_qout;

  csr_unit #(.XLEN(XLEN), .RB(RB), .HARTID(HART), .CNT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .csr_exeparam_valid(csr_exeparam_valid), .csr_exeparam(csr_exeparam),
    .flush(flush), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .retire_cnt(retire_cnt), .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .csr_writeback_valid(csr_writeback_valid), .csr_res_qout(csr_res_qout),
    .csr_rd0_qout(csr_rd0_qout), .csr_illegal(csr_illegal),
    .mtvec_qout(mtvec_qout), .mepc_qout(mepc_qout),
    .mstatus_mie(mstatus_mie), .mip_mie_qout(mip_mie_qout)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural model state, kept as individual fields rather than masked words.
  bit          m_gie, m_mpie, m_ie_s, m_ie_t, m_ie_e;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cycle, m_instret;
  logic        e_valid = 1'b0, e_ill = 1'b0;
  logic [63:0] e_res = '0;
  logic [TW-1:0] e_rd = '0;
  bit          started = 1'b0;

  task automatic model_read(input logic [11:0] a, output logic [63:0] v,
                            output bit known, output bit ro);
    known = 1'b1; ro = 1'b0; v = '0;
    case (a)
      12'hF11, 12'hF12, 12'hF13: ro = 1'b1;
      12'hF14: begin ro = 1'b1; v = HART; end
      12'h301: v = 64'h8000_0000_0000_0100;
      12'h300: v = 64'h1800 + (m_mpie ? 64'h80 : 64'h0) + (m_gie ? 64'h8 : 64'h0);
      12'h304: v = (m_ie_e ? 64'h800 : 64'h0) + (m_ie_t ? 64'h80 : 64'h0)
                   + (m_ie_s ? 64'h8 : 64'h0);
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (irq_meip ? 64'h800 : 64'h0) + (irq_mtip ? 64'h80 : 64'h0)
                   + (irq_msip ? 64'h8 : 64'h0);
      12'hB00: v = m_cycle;
      12'hB02: v = m_instret;
      12'hC00: begin ro = 1'b1; v = m_cycle; end
      12'hC02: begin ro = 1'b1; v = m_instret; end
      default: known = 1'b0;
    endcase
  endtask

  task automatic model_step();
    logic [11:0] a;
    logic [63:0] op, rv, nv, nxt_cyc, nxt_ret;
    logic [TW-1:0] rd;
    logic rw, rs, rc, rz;
    bit known, ro, wi, ill, act;
    if (RST) begin
      {m_gie, m_mpie, m_ie_s, m_ie_t, m_ie_e} = '0;
      m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
      m_cycle = '0; m_instret = '0;
      e_valid = 1'b0; e_ill = 1'b0; e_res = '0; e_rd = '0;
      started = 1'b1;
    end else begin
      {rw, rs, rc, rz, rd, op, a} = csr_exeparam;
      model_read(a, rv, known, ro);
      wi  = rw || (!rz && (rs || rc));
      ill = !known || ((int'(rw) + int'(rs) + int'(rc)) != 1) || (ro && wi);
      act = csr_exeparam_valid && !trap_valid && !mret_valid;
      e_valid = 1'b0; e_ill = 1'b0; e_res = '0; e_rd = '0;
      nxt_cyc = m_cycle + 64'd1;
      nxt_ret = m_instret + 64'(retire_cnt);
      if (act && !flush) begin
        if (ill) e_ill = 1'b1;
        else begin
          e_valid = 1'b1;
          e_rd    = rd;
          e_res   = (rw && rd == '0) ? 64'h0 : rv;
          if (wi) begin
            nv = rw ? op : (rs ? (rv | op) : (rv & ~op));
            case (a)
              12'h300: begin m_gie = nv[3]; m_mpie = nv[7]; end
              12'h304: begin m_ie_s = nv[3]; m_ie_t = nv[7]; m_ie_e = nv[11]; end
              12'h305: m_mtvec = {nv[63:2], 2'b00};
              12'h340: m_mscratch = nv;
              12'h341: m_mepc = {nv[63:2], 2'b00};
              12'h342: m_mcause = nv;
              12'h343: m_mtval = nv;
              12'hB00: nxt_cyc = nv;
              12'hB02: nxt_ret = nv;
              default: ;
            endcase
          end
        end
      end
      m_cycle   = nxt_cyc;
      m_instret = nxt_ret;
      if (trap_valid) begin
        m_mepc = {trap_epc[63:2], 2'b00}; m_mcause = trap_cause; m_mtval = trap_tval;
        m_mpie = m_gie; m_gie = 1'b0;
      end else if (mret_valid) begin
        m_gie = m_mpie; m_mpie = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  always @(negedge CLK) begin
    if (started) begin
      check("wb_valid", 64'(csr_writeback_valid), 64'(e_valid));
      check("illegal", 64'(csr_illegal), 64'(e_ill));
      check("res", csr_res_qout, e_res);
      check("rd0", 64'(csr_rd0_qout), 64'(e_rd));
      check("mtvec", mtvec_qout, m_mtvec);
      check("mepc", mepc_qout, m_mepc);
      check("mstatus_mie", 64'(mstatus_mie), 64'(m_gie));
      check("mip_mie", mip_mie_qout, {52'b0, irq_meip & m_ie_e, 3'b0, irq_mtip & m_ie_t,
                                      3'b0, irq_msip & m_ie_s, 3'b0});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    csr_exeparam_valid = 1'b0; csr_exeparam = '0;
    flush = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  task automatic op_set(input logic [2:0] kind, input logic rz, input logic [TW-1:0] rd,
                        input logic [63:0] op, input logic [11:0] a);
    csr_exeparam_valid = 1'b1;
    csr_exeparam = {kind, rz, rd, op, a};
  endtask

  task automatic do_op(input logic [2:0] kind, input logic rz, input logic [TW-1:0] rd,
                       input logic [63:0] op, input logic [11:0] a);
    op_set(kind, rz, rd, op, a);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; csr_exeparam_valid = 1'b0; csr_exeparam = '0;
    flush = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    trap_cause = '0; trap_epc = '0; trap_tval = '0; retire_cnt = 2'd0;
    irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("lit_rst_valid", 64'(csr_writeback_valid), 64'h0);
    check("lit_rst_res", csr_res_qout, 64'h0);
    check("lit_rst_mepc", mepc_qout, 64'h0);

    // mscratch write, then read with rs1_zero (nonzero op must not write)
    do_op(RW, 1'b0, 7'd5, 64'hDEAD_BEEF, 12'h340);
    check("lit_rw_valid", 64'(csr_writeback_valid), 64'h1);
    check("lit_rw_res", csr_res_qout, 64'h0);
    check("lit_rw_rd", 64'(csr_rd0_qout), 64'd5);
    do_op(RS, 1'b1, 7'd6, 64'hFFFF, 12'h340);
    check("lit_rs_res", csr_res_qout, 64'hDEAD_BEEF);
    do_op(RS, 1'b1, 7'd6, 64'h0, 12'h340);
    check("lit_nowrite", csr_res_qout, 64'hDEAD_BEEF);

    // mstatus masks
    do_op(RW, 1'b0, 7'd1, '1, 12'h300);
    check("lit_mstatus_rst", csr_res_qout, 64'h1800);
    do_op(RC, 1'b0, 7'd1, 64'h8, 12'h300);
    check("lit_mstatus_all", csr_res_qout, 64'h1888);
    do_op(RS, 1'b1, 7'd1, 64'h0, 12'h300);
    check("lit_mstatus_clr", csr_res_qout, 64'h1880);
    do_op(RS, 1'b0, 7'd1, 64'h8, 12'h300);
    check("lit_mie_set", 64'(mstatus_mie), 64'h1);

    // trap entry and MRET
    trap_valid = 1'b1; trap_epc = 64'h8000_0103; trap_cause = 64'd11; trap_tval = 64'hBAD;
    tick();
    check("lit_trap_mepc", mepc_qout, 64'h8000_0100);
    check("lit_trap_mie", 64'(mstatus_mie), 64'h0);
    do_op(RS, 1'b1, 7'd2, 64'h0, 12'h342);
    check("lit_mcause", csr_res_qout, 64'd11);
    do_op(RS, 1'b1, 7'd2, 64'h0, 12'h343);
    check("lit_mtval", csr_res_qout, 64'hBAD);
    do_op(RS, 1'b1, 7'd2, 64'h0, 12'h300);
    check("lit_trap_mstatus", csr_res_qout, 64'h1880);
    mret_valid = 1'b1;
    tick();
    do_op(RS, 1'b1, 7'd2, 64'h0, 12'h300);
    check("lit_mret_mstatus", csr_res_qout, 64'h1888);

    // illegal accesses
    do_op(RW, 1'b0, 7'd3, 64'h5, 12'hC00);
    check("lit_ill_c00", 64'(csr_illegal), 64'h1);
    check("lit_ill_c00_valid", 64'(csr_writeback_valid), 64'h0);
    do_op(RS, 1'b1, 7'd3, 64'h0, 12'h7C0);
    check("lit_ill_7c0", 64'(csr_illegal), 64'h1);
    do_op(RS, 1'b1, 7'd3, 64'h0, 12'hC00);
    check("lit_cycle_legal", 64'(csr_writeback_valid), 64'h1);
    do_op(3'b110, 1'b0, 7'd3, 64'h5, 12'h340);
    check("lit_ill_onehot", 64'(csr_illegal), 64'h1);
    do_op(RW, 1'b0, 7'd3, 64'h0, 12'hF14);
    check("lit_ill_f14", 64'(csr_illegal), 64'h1);
    do_op(RS, 1'b1, 7'd3, 64'h0, 12'hF14);
    check("lit_hartid", csr_res_qout, 64'h7);
    do_op(RW, 1'b0, 7'd3, 64'h0, 12'h301);
    check("lit_misa", csr_res_qout, 64'h8000_0000_0000_0100);
    do_op(RS, 1'b1, 7'd3, 64'h0, 12'h340);
    check("lit_ill_nochange", csr_res_qout, 64'hDEAD_BEEF);

    // counter wrap and minstret accumulation
    do_op(RW, 1'b0, 7'd4, 64'hFFFF_FFFF_FFFF_FFFE, 12'hB00);
    tick();
    do_op(RS, 1'b1, 7'd4, 64'h0, 12'hB00);
    check("lit_mcycle_max", csr_res_qout, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(RS, 1'b1, 7'd4, 64'h0, 12'hB00);
    check("lit_mcycle_wrap", csr_res_qout, 64'h0);
    do_op(RW, 1'b0, 7'd4, 64'd100, 12'hB02);
    retire_cnt = 2'd2;
    repeat (3) tick();
    retire_cnt = 2'd0;
    do_op(RS, 1'b1, 7'd4, 64'h0, 12'hC02);
    check("lit_minstret", csr_res_qout, 64'd106);

    // trap beats a same-cycle CSR write; flush suppresses write and writeback
    trap_valid = 1'b1; trap_epc = 64'h2000; trap_cause = 64'd3; trap_tval = 64'h0;
    op_set(RW, 1'b0, 7'd5, 64'h1234, 12'h341);
    tick();
    check("lit_trap_op_valid", 64'(csr_writeback_valid), 64'h0);
    check("lit_trap_op_mepc", mepc_qout, 64'h2000);
    flush = 1'b1;
    op_set(RW, 1'b0, 7'd5, 64'h77, 12'h340);
    tick();
    check("lit_flush_valid", 64'(csr_writeback_valid), 64'h0);
    do_op(RS, 1'b1, 7'd5, 64'h0, 12'h340);
    check("lit_flush_nowrite", csr_res_qout, 64'hDEAD_BEEF);
    mret_valid = 1'b1;
    op_set(RW, 1'b0, 7'd5, 64'h0, 12'h300);
    tick();

    // rw with rd0 == 0 suppresses the read but still writes
    do_op(RW, 1'b0, 7'd0, 64'h42, 12'h340);
    check("lit_rd0_zero_res", csr_res_qout, 64'h0);
    do_op(RS, 1'b1, 7'd1, 64'h0, 12'h340);
    check("lit_rd0_zero_wr", csr_res_qout, 64'h42);

    // mie/mip and mtvec
    do_op(RW, 1'b0, 7'd1, '1, 12'h304);
    irq_mtip = 1'b1;
    tick();
    check("lit_mip_mie_t", mip_mie_qout, 64'h80);
    do_op(RS, 1'b1, 7'd1, 64'h0, 12'h344);
    check("lit_mip_read", csr_res_qout, 64'h80);
    irq_meip = 1'b1;
    do_op(RC, 1'b0, 7'd1, 64'h80, 12'h304);
    check("lit_mip_mie_e", mip_mie_qout, 64'h800);
    do_op(RW, 1'b0, 7'd1, 64'h1003, 12'h305);
    check("lit_mtvec", mtvec_qout, 64'h1000);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
